// File: rtl/snoop_pkg.sv
// Shared encodings for the MSI snooping controller (receptor and emitter).
// Holds state/message/action constants, the receptor FSM type and the snoop transition rule.
package snoop_pkg;

  localparam logic [1:0] INVALID  = 2'd0;
  localparam logic [1:0] SHARED   = 2'd1;
  localparam logic [1:0] MODIFIED = 2'd2;

  localparam logic [1:0] MSG_NONE   = 2'd0;
  localparam logic [1:0] READ_MISS  = 2'd1;
  localparam logic [1:0] WRITE_MISS = 2'd2;
  localparam logic [1:0] INVALIDATE = 2'd3;

  localparam logic [1:0] NONE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ABORT     = 2'd2;
  localparam logic [1:0] WB_ABORT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_RESPOND = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] next_state;
    logic [1:0] action;
    logic       error;
  } snoop_result_t;

  // Snoop-side MSI transition for one looked-up line; a miss leaves the line untouched.
  function automatic snoop_result_t snoop_resolve(input logic [1:0] msg,
                                                  input logic [1:0] state,
                                                  input logic       tag_match);
    snoop_result_t r;
    r            = '0;
    r.next_state = state;
    r.action     = NONE;
    if (tag_match && (state != INVALID)) begin
      r.hit = 1'b1;
      case (state)
        SHARED: begin
          r.next_state = (msg == READ_MISS) ? SHARED : INVALID;
        end
        MODIFIED: begin
          case (msg)
            READ_MISS: begin
              r.next_state = SHARED;
              r.action     = WB_ABORT;
            end
            WRITE_MISS: begin
              r.next_state = INVALID;
              r.action     = WB_ABORT;
            end
            INVALIDATE: begin
              r.next_state = INVALID;
              r.error      = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/snoop_line_array.sv
// Per-line tag/state registers with a single write port and combinational read.
// Tag is only rewritten on local installs; snoops change state alone.
module snoop_line_array
  import snoop_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 4
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         we_i,
  input  logic                         tag_we_i,
  input  logic [$clog2(NUM_LINES)-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]             wr_tag_i,
  input  logic [1:0]                   wr_state_i,
  input  logic [$clog2(NUM_LINES)-1:0] rd_idx_i,
  output logic [TAG_W-1:0]             rd_tag_o,
  output logic [1:0]                   rd_state_o,
  output logic [2*NUM_LINES-1:0]       line_state_o
);

  logic [TAG_W-1:0] tag_q   [NUM_LINES];
  logic [1:0]       state_q [NUM_LINES];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= INVALID;
      end
    end else if (we_i) begin
      state_q[wr_idx_i] <= wr_state_i;
      if (tag_we_i) begin
        tag_q[wr_idx_i] <= wr_tag_i;
      end
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_state_o = state_q[rd_idx_i];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_pack
      assign line_state_o[2*gi +: 2] = state_q[gi];
    end
  endgenerate

endmodule

// File: rtl/snoop_receptor.sv
// Bus-side snoop receptor: IDLE -> LOOKUP -> (RESPOND) applying MSI snoop transitions.
// Define SNOOP_STATS_EN to add saturating hit / writeback counters.
module snoop_receptor
  import snoop_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Valid,
  input  logic [1:0]                   i_Message,
  input  logic [$clog2(NUM_LINES)-1:0] i_Index,
  input  logic [TAG_W-1:0]             i_Tag,
  output logic                         o_Ready,
  output logic [1:0]                   o_Action,
  output logic                         o_ActValid,
  input  logic                         i_Ack,
  output logic                         o_Done,
  output logic                         o_Error,
  input  logic                         i_LocalWe,
  input  logic [$clog2(NUM_LINES)-1:0] i_LocalIndex,
  input  logic [TAG_W-1:0]             i_LocalTag,
  input  logic [1:0]                   i_LocalState,
  output logic                         o_LocalReady,
  output logic [2*NUM_LINES-1:0]       o_LineState
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]                  o_HitCount,
  output logic [15:0]                  o_WbCount
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);

  fsm_state_e       fsm_q, fsm_d;
  logic [1:0]       msg_q, msg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       action_q, action_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             bus_accept;
  logic             local_accept;
  logic             snoop_we;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_state;
  logic [1:0]       local_state;
  snoop_result_t    res;

  assign bus_accept   = i_Valid && (i_Message != MSG_NONE);
  // Bus wins over a same-cycle local install; the installer simply retries.
  assign local_accept = (fsm_q == S_IDLE) && !bus_accept && i_LocalWe && !i_Reset;
  assign res          = snoop_resolve(msg_q, rd_state, rd_tag == tag_q);
  assign snoop_we     = (fsm_q == S_LOOKUP) && res.hit;
  assign local_state  = (i_LocalState == 2'd3) ? INVALID : i_LocalState;

  snoop_line_array #(
    .NUM_LINES(NUM_LINES),
    .TAG_W    (TAG_W)
  ) u_lines (
    .clk_i       (i_Clock),
    .srst_i      (i_Reset),
    .we_i        (snoop_we || local_accept),
    .tag_we_i    (!snoop_we),
    .wr_idx_i    (snoop_we ? idx_q : i_LocalIndex),
    .wr_tag_i    (i_LocalTag),
    .wr_state_i  (snoop_we ? res.next_state : local_state),
    .rd_idx_i    (idx_q),
    .rd_tag_o    (rd_tag),
    .rd_state_o  (rd_state),
    .line_state_o(o_LineState)
  );

  always_comb begin
    fsm_d    = fsm_q;
    msg_d    = msg_q;
    idx_d    = idx_q;
    tag_d    = tag_q;
    action_d = action_q;
    done_d   = 1'b0;
    error_d  = error_q;
    case (fsm_q)
      S_IDLE: begin
        if (bus_accept) begin
          msg_d = i_Message;
          idx_d = i_Index;
          tag_d = i_Tag;
          fsm_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        error_d = error_q | res.error;
        if (res.action != NONE) begin
          action_d = res.action;
          fsm_d    = S_RESPOND;
        end else begin
          done_d = 1'b1;
          fsm_d  = S_IDLE;
        end
      end
      S_RESPOND: begin
        if (i_Ack) begin
          action_d = NONE;
          done_d   = 1'b1;
          fsm_d    = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      fsm_q    <= S_IDLE;
      msg_q    <= MSG_NONE;
      idx_q    <= '0;
      tag_q    <= '0;
      action_q <= NONE;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      msg_q    <= msg_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      action_q <= action_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign o_Ready      = (fsm_q == S_IDLE) || i_Reset;
  assign o_LocalReady = local_accept;
  assign o_ActValid   = (fsm_q == S_RESPOND);
  assign o_Action     = action_q;
  assign o_Done       = done_q;
  assign o_Error      = error_q;

`ifdef SNOOP_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] wb_cnt_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      hit_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else if (fsm_q == S_LOOKUP) begin
      if (res.hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (res.action[0] && (wb_cnt_q != 16'hFFFF)) begin
        wb_cnt_q <= wb_cnt_q + 16'd1;
      end
    end
  end

  assign o_HitCount = hit_cnt_q;
  assign o_WbCount  = wb_cnt_q;
`endif

endmodule

// File: tb/tb_snoop_receptor.sv
// Directed bench for snoop_receptor: a transaction-level MSI model checked every cycle,
// plus literal expectations for each scenario.
module tb_snoop_receptor;

  localparam int NL = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          i_Reset, i_Valid, i_Ack, i_LocalWe;
  logic [1:0]    i_Message, i_LocalState;
  logic [1:0]    i_Index, i_LocalIndex;
  logic [TW-1:0] i_Tag, i_LocalTag;
  logic          o_Ready, o_ActValid, o_Done, o_Error, o_LocalReady;
  logic [1:0]    o_Action;
  logic [2*NL-1:0] o_LineState;
`ifdef SNOOP_STATS_EN
  logic [15:0]   o_HitCount, o_WbCount;
`endif

  always #5 clk = ~clk;

  snoop_receptor #(.NUM_LINES(NL), .TAG_W(TW)) dut (
    .i_Clock     (clk),
    .i_Reset     (i_Reset),
    .i_Valid     (i_Valid),
    .i_Message   (i_Message),
    .i_Index     (i_Index),
    .i_Tag       (i_Tag),
    .o_Ready     (o_Ready),
    .o_Action    (o_Action),
    .o_ActValid  (o_ActValid),
    .i_Ack       (i_Ack),
    .o_Done      (o_Done),
    .o_Error     (o_Error),
    .i_LocalWe   (i_LocalWe),
    .i_LocalIndex(i_LocalIndex),
    .i_LocalTag  (i_LocalTag),
    .i_LocalState(i_LocalState),
    .o_LocalReady(o_LocalReady),
    .o_LineState (o_LineState)
`ifdef SNOOP_STATS_EN
    ,
    .o_HitCount  (o_HitCount),
    .o_WbCount   (o_WbCount)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 waiting, 1 message pending lookup, 2 waiting for ack.
  logic [1:0]    m_state [NL];
  logic [TW-1:0] m_tag   [NL];
  int            m_phase;
  logic [1:0]    m_msg, m_act;
  int            m_idx;
  logic [TW-1:0] m_ltag;
  logic          m_done, m_err;
  int            m_hits, m_wbs;

  function automatic void msi_rule(input logic [1:0] st, input logic [1:0] msg,
                                   output logic [1:0] nst, output logic [1:0] act,
                                   output logic err);
    nst = st;
    act = 2'd0;
    err = 1'b0;
    if (st == 2'd1) begin
      nst = (msg == 2'd1) ? 2'd1 : 2'd0;
    end else if (st == 2'd2) begin
      nst = (msg == 2'd1) ? 2'd1 : 2'd0;
      act = (msg == 2'd3) ? 2'd0 : 2'd3;
      err = (msg == 2'd3);
    end
  endfunction

  always @(posedge clk) begin
    logic [1:0] nst, act;
    logic       err;
    m_done = 1'b0;
    if (i_Reset) begin
      for (int i = 0; i < NL; i++) begin
        m_state[i] = 2'd0;
        m_tag[i]   = '0;
      end
      m_phase = 0;
      m_act   = 2'd0;
      m_err   = 1'b0;
      m_hits  = 0;
      m_wbs   = 0;
    end else if (m_phase == 0) begin
      if (i_Valid && i_Message != 2'd0) begin
        m_msg   = i_Message;
        m_idx   = int'(i_Index);
        m_ltag  = i_Tag;
        m_phase = 1;
      end else if (i_LocalWe) begin
        m_state[i_LocalIndex] = (i_LocalState == 2'd3) ? 2'd0 : i_LocalState;
        m_tag[i_LocalIndex]   = i_LocalTag;
      end
    end else if (m_phase == 1) begin
      if (m_tag[m_idx] == m_ltag && m_state[m_idx] != 2'd0) begin
        msi_rule(m_state[m_idx], m_msg, nst, act, err);
        m_state[m_idx] = nst;
        m_hits++;
        if (act[0]) m_wbs++;
        if (err) m_err = 1'b1;
      end else begin
        act = 2'd0;
      end
      if (act != 2'd0) begin
        m_act   = act;
        m_phase = 2;
      end else begin
        m_done  = 1'b1;
        m_phase = 0;
      end
    end else begin
      if (i_Ack) begin
        m_act   = 2'd0;
        m_done  = 1'b1;
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [2*NL-1:0] exp_ls;
    if (chk_en) begin
      for (int i = 0; i < NL; i++) exp_ls[2*i +: 2] = m_state[i];
      chk("ready", 32'(o_Ready), 32'((m_phase == 0) || i_Reset));
      chk("local_ready", 32'(o_LocalReady),
          32'((m_phase == 0) && !(i_Valid && i_Message != 2'd0) && i_LocalWe && !i_Reset));
      chk("act_valid", 32'(o_ActValid), 32'(m_phase == 2));
      chk("action", 32'(o_Action), 32'(m_act));
      chk("done", 32'(o_Done), 32'(m_done));
      chk("error", 32'(o_Error), 32'(m_err));
      chk("line_state", 32'(o_LineState), 32'(exp_ls));
`ifdef SNOOP_STATS_EN
      chk("hit_count", 32'(o_HitCount), 32'(m_hits));
      chk("wb_count", 32'(o_WbCount), 32'(m_wbs));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic install(input int idx, input int tag, input int st);
    i_LocalWe    = 1'b1;
    i_LocalIndex = 2'(idx);
    i_LocalTag   = TW'(tag);
    i_LocalState = 2'(st);
    tick();
    i_LocalWe    = 1'b0;
  endtask

  // Returns one cycle after the accepting edge (the lookup cycle).
  task automatic snoop(input int msg, input int idx, input int tag);
    i_Valid   = 1'b1;
    i_Message = 2'(msg);
    i_Index   = 2'(idx);
    i_Tag     = TW'(tag);
    tick();
    i_Valid   = 1'b0;
    i_Message = 2'd0;
  endtask

  initial begin
    i_Reset = 1'b1; i_Valid = 1'b0; i_Ack = 1'b0; i_LocalWe = 1'b0;
    i_Message = '0; i_Index = '0; i_Tag = '0;
    i_LocalIndex = '0; i_LocalTag = '0; i_LocalState = '0;
    repeat (2) tick();
    chk_en = 1'b1;
    chk("reset_line_state", 32'(o_LineState), 32'h0);
    chk("reset_ready", 32'(o_Ready), 32'h1);
    chk("reset_local_ready", 32'(o_LocalReady), 32'h0);
    i_Reset = 1'b0;

    // SHARED line hit by WRITE_MISS: no action, done at N+2, line invalidated
    install(2, 5, 1);
    chk("t1_installed", 32'(o_LineState[5:4]), 32'd1);
    snoop(2, 2, 5);
    tick();
    chk("t1_done", 32'(o_Done), 32'h1);
    chk("t1_line2", 32'(o_LineState[5:4]), 32'd0);
    chk("t1_ready", 32'(o_Ready), 32'h1);
    tick();
    chk("t1_done_pulse", 32'(o_Done), 32'h0);

    // MODIFIED line hit by READ_MISS: WB+ABORT held until ack
    install(1, 3, 2);
    snoop(1, 1, 3);
    tick();
    chk("t2_actvalid", 32'(o_ActValid), 32'h1);
    chk("t2_action", 32'(o_Action), 32'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_hold", 32'(o_Action), 32'd3);
    end
    i_Ack = 1'b1;
    tick();
    chk("t2_done", 32'(o_Done), 32'h1);
    chk("t2_line1", 32'(o_LineState[3:2]), 32'd1);
    chk("t2_actvalid_drop", 32'(o_ActValid), 32'h0);
    i_Ack = 1'b0;

    // Ack already high: WRITE_MISS on MODIFIED line completes at N+3
    install(3, 2, 2);
    i_Ack = 1'b1;
    snoop(2, 3, 2);
    tick();
    chk("t2b_actvalid", 32'(o_ActValid), 32'h1);
    tick();
    chk("t2b_done", 32'(o_Done), 32'h1);
    chk("t2b_line3", 32'(o_LineState[7:6]), 32'd0);
    i_Ack = 1'b0;

    // Tag mismatch: no action, line stays MODIFIED
    install(1, 3, 2);
    snoop(2, 1, 4);
    tick();
    chk("t3_done", 32'(o_Done), 32'h1);
    chk("t3_actvalid", 32'(o_ActValid), 32'h0);
    chk("t3_line1", 32'(o_LineState[3:2]), 32'd2);

    // INVALIDATE on MODIFIED: sticky error
    install(0, 7, 2);
    snoop(3, 0, 7);
    tick();
    chk("t4_line0", 32'(o_LineState[1:0]), 32'd0);
    chk("t4_error", 32'(o_Error), 32'h1);
    chk("t4_done", 32'(o_Done), 32'h1);
    repeat (3) tick();
    chk("t4_error_sticky", 32'(o_Error), 32'h1);

    // Local state 3 installs as INVALID
    install(2, 6, 1);
    chk("t5_shared", 32'(o_LineState[5:4]), 32'd1);
    install(2, 6, 3);
    chk("t5_state3_invalid", 32'(o_LineState[5:4]), 32'd0);

    // Bus and local install in the same cycle: bus wins, local retried
    i_Valid = 1'b1; i_Message = 2'd1; i_Index = 2'd3; i_Tag = 4'd9;
    i_LocalWe = 1'b1; i_LocalIndex = 2'd3; i_LocalTag = 4'd9; i_LocalState = 2'd1;
    #1;
    chk("t5_local_blocked", 32'(o_LocalReady), 32'h0);
    tick();
    i_Valid = 1'b0; i_Message = 2'd0;
    chk("t5_local_in_lookup", 32'(o_LocalReady), 32'h0);
    tick();
    chk("t5_local_ready", 32'(o_LocalReady), 32'h1);
    tick();
    i_LocalWe = 1'b0;
    chk("t5_line3", 32'(o_LineState[7:6]), 32'd1);

    // Reset while in RESPOND aborts the snoop and clears everything
    install(1, 3, 2);
    snoop(1, 1, 3);
    tick();
    chk("t6_actvalid", 32'(o_ActValid), 32'h1);
    i_Reset = 1'b1;
    tick();
    chk("t6_actvalid_drop", 32'(o_ActValid), 32'h0);
    chk("t6_states", 32'(o_LineState), 32'h0);
    chk("t6_no_done", 32'(o_Done), 32'h0);
    chk("t6_error_clr", 32'(o_Error), 32'h0);
`ifdef SNOOP_STATS_EN
    chk("t6_hits_clr", 32'(o_HitCount), 32'h0);
    chk("t6_wbs_clr", 32'(o_WbCount), 32'h0);
`endif
    i_Reset = 1'b0;
    tick();
    chk("t6_ready", 32'(o_Ready), 32'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/snoop_receptor.md
# snoop_receptor

Bus-side half of the MSI snooping controller. It receives coherence messages (READ_MISS, WRITE_MISS, INVALIDATE) broadcast by another core's emitter and looks up the addressed line in a small local state/tag array. It applies the snoop-side MSI transition and issues the required bus action (none, WRITEBACK, WRITEBACK+ABORT). It sits between the shared bus and the local cache, alongside the local request emitter, which installs line states through a separate local port.

## Interface
- NUM_LINES, 4, number of tracked lines (power of two, ≥2)
- TAG_W, 4, tag width in bits
- i_Clock  in  1  rising-edge clock
- i_Reset  in  1  reset, synchronous and active-high
- i_Valid  in  1  bus message present
- i_Message  in  2  0 none, 1 READ_MISS, 2 WRITE_MISS, 3 INVALIDATE
- i_Index  in  log2(NUM_LINES)  line index of snooped address
- i_Tag  in  TAG_W  tag of snooped address
- o_Ready  out  1  receptor can accept a bus message
- o_Action  out  2  0 none, 1 WRITEBACK, 2 ABORT, 3 WRITEBACK+ABORT
- o_ActValid  out  1  o_Action valid, held until i_Ack
- i_Ack  in  1  bus has taken the action
- o_Done  out  1  one-cycle pulse when a snoop completes
- o_Error  out  1  sticky: INVALIDATE seen on a MODIFIED line
- i_LocalWe  in  1  local install request
- i_LocalIndex  in  log2(NUM_LINES)  local install index
- i_LocalTag  in  TAG_W  local install tag
- i_LocalState  in  2  0 INVALID, 1 SHARED, 2 MODIFIED
- o_LocalReady  out  1  local install accepted this cycle
- o_LineState  out  2*NUM_LINES  packed current states, line 0 in LSBs

## Operation
- FSM states: IDLE, LOOKUP, RESPOND.
- IDLE: o_Ready=1. i_Valid with i_Message≠0 latches message, index and tag, then goes to LOOKUP. i_Message=0 is ignored.
- LOOKUP: a hit requires stored tag = latched tag and state≠INVALID. A miss means no action and no state change.
- Transitions on hit:
  - SHARED: READ_MISS → SHARED, action none.
  - SHARED: WRITE_MISS or INVALIDATE → INVALID, action none.
  - MODIFIED: READ_MISS → SHARED, WRITEBACK+ABORT.
  - MODIFIED: WRITE_MISS → INVALID, WRITEBACK+ABORT.
  - MODIFIED: INVALIDATE → INVALID, action none, o_Error set.
- The state array is written at the end of LOOKUP.
- Leaving LOOKUP:
  - action≠none → RESPOND.
  - action=none → IDLE with o_Done pulse.
- RESPOND: o_ActValid=1 with o_Action stable. On i_Ack, go to IDLE and pulse o_Done.
- Local install: accepted only in IDLE with no accepted bus message the same cycle. The bus has priority. o_LocalReady = IDLE & ~(i_Valid & i_Message≠0) & i_LocalWe. The write takes effect on the next edge. i_LocalState=3 is written as INVALID.

## Timing
- Reset values:
  - FSM in IDLE.
  - All line states INVALID, tags 0.
  - o_Ready=1 and o_LocalReady=0 (both held at these values during reset).
  - o_Action=0, o_ActValid=0, o_Done=0, o_Error=0, counters 0.
- Accept at edge N. LOOKUP during cycle N+1. New state visible on o_LineState from N+2.
- Action path: o_ActValid rises at N+2. With i_Ack already high at N+2, IDLE and o_Done at N+3.
- No-action path: o_Done is high in cycle N+2 and o_Ready=1 in N+2.
- Throughput is one message per 2 cycles (no action) or 3 cycles or more (action).
- i_Ack outside RESPOND is ignored.
- Reset mid-operation aborts any snoop. No o_Done is produced, o_ActValid drops the next cycle, and the array clears.

## Configuration
- SNOOP_STATS_EN defined adds two ports:
  - o_HitCount (16) counts LOOKUP hits.
  - o_WbCount (16) counts actions containing WRITEBACK.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent. All other behaviour is identical.

## Structure
- Package snoop_pkg holds:
  - state constants INVALID/SHARED/MODIFIED.
  - message constants READ_MISS/WRITE_MISS/INVALIDATE.
  - action constants NONE/WRITEBACK/ABORT/WB_ABORT.
  - The emitter shares the same encodings.
- One sub-module, snoop_line_array: NUM_LINES tag/state registers with one write port (arbitrated snoop/local) and combinational read.

## Test plan
- Install line 2, tag 5, SHARED. Snoop WRITE_MISS idx 2 tag 5 → action none, o_Done at N+2, line 2 INVALID.
- Install line 1, tag 3, MODIFIED. Snoop READ_MISS → o_Action=3 at N+2. Hold i_Ack=0 for 4 cycles: o_Action stays 3. Ack → line 1 SHARED, o_Done.
- Install line 1, tag 3, MODIFIED. Snoop WRITE_MISS with tag 4 (mismatch) → no action, line 1 stays MODIFIED.
- MODIFIED line 0 plus INVALIDATE → line 0 INVALID, o_Error=1 and stays 1 until reset.
- Same-cycle i_Valid READ_MISS and i_LocalWe → o_LocalReady=0. Local accepted on the next IDLE cycle.
- Assert i_Reset while in RESPOND → next cycle o_ActValid=0, all states INVALID. With SNOOP_STATS_EN, counters read 0.
